// File: rtl/axis_tx_gen_pkg.sv
// Shared types and helpers for the deterministic AXI-Stream TX packet generator:
// FSM state encoding, beat geometry, last-beat byte enables and the payload byte pattern.
`timescale 1ns/1ps

package axis_tx_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int BYTES_PER_BEAT = 8;

    // len_mod is the packet length modulo 8; zero means the last beat is full.
    function automatic logic [7:0] last_tkeep(input logic [2:0] len_mod);
        logic [8:0] mask;
        mask = (9'd1 << len_mod) - 9'd1;
        return (len_mod == 3'd0) ? 8'hFF : mask[7:0];
    endfunction

    function automatic logic [7:0] pattern_byte(input logic [7:0] seed, input logic [7:0] k);
        return seed + k;
    endfunction

endpackage

// File: rtl/axis_tx_pattern_gen.sv
// Combinational beat builder: lane j of beat b carries byte k = 8*b + j of the packet,
// lanes past the packet end are zeroed and masked off in keep.
`timescale 1ns/1ps

module axis_tx_pattern_gen
    import axis_tx_gen_pkg::*;
(
    input  logic [7:0]                  seed,
    input  logic [4:0]                  beat_lsb,
    input  logic [2:0]                  len_mod,
    input  logic                        is_last,
    input  logic                        flip_byte0,
    output logic [BYTES_PER_BEAT*8-1:0] data,
    output logic [BYTES_PER_BEAT-1:0]   keep
);

    always_comb begin
        keep = is_last ? last_tkeep(len_mod) : '1;
        data = '0;
        // Only the low 8 bits of the byte index matter since the pattern is mod 256.
        for (int j = 0; j < BYTES_PER_BEAT; j++) begin
            if (keep[j]) begin
                data[j*8 +: 8] = pattern_byte(seed, {beat_lsb, 3'(j)});
            end
        end
        if (flip_byte0) begin
            data[7:0] = data[7:0] ^ 8'hFF;
        end
    end

endmodule

// File: rtl/axis_tx_pkt_gen.sv
// AXI-Stream master producing deterministic Ethernet payload packets for the MAC TX path.
// Optional feature: define AXIS_TX_ERR_INJ_EN to add cfg_err_every / err_inj byte-0 corruption.
`timescale 1ns/1ps

module axis_tx_pkt_gen
    import axis_tx_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BCNT_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  tx_mac_aclk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic [LEN_WIDTH-1:0]  cfg_min_len,
    input  logic [LEN_WIDTH-1:0]  cfg_max_len,
    input  logic [LEN_WIDTH-1:0]  cfg_len_step,
    input  logic [7:0]            cfg_gap,
    input  logic [31:0]           cfg_num_pkts,
`ifdef AXIS_TX_ERR_INJ_EN
    input  logic [7:0]            cfg_err_every,
    output logic                  err_inj,
`endif
    input  logic                  tx_axis_mac_tready,
    output logic                  tx_axis_mac_tvalid,
    output logic [DATA_WIDTH-1:0] tx_axis_mac_tdata,
    output logic [7:0]            tx_axis_mac_tkeep,
    output logic                  tx_axis_mac_tlast,
    output logic [BCNT_WIDTH-1:0] tx_axis_mac_tbcnt,
    output logic [31:0]           pkt_cnt,
    output logic                  busy,
    output logic                  done
);

    localparam int BEAT_WIDTH = LEN_WIDTH - 3;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  min_q, max_q, step_q, len_q;
    logic [LEN_WIDTH-1:0]  eff_min, len_next;
    logic [LEN_WIDTH:0]    len_sum;
    logic [7:0]            gap_q, gap_cnt_q;
    logic [31:0]           num_q, pkt_cnt_q, cnt_inc;
    logic [BEAT_WIDTH-1:0] beat_q;
    logic                  stop_q, done_q;
    logic                  valid, hs, last_beat, pkt_end, run_end, start_run;
    logic                  flip_byte0;
    logic [DATA_WIDTH-1:0] pat_data;
    logic [7:0]            pat_keep;

    assign valid     = (state_q == SEND);
    assign hs        = valid & tx_axis_mac_tready;
    assign start_run = (state_q == IDLE) & cfg_start;
    assign last_beat = ({1'b0, beat_q, 3'b000} + (LEN_WIDTH+1)'(BYTES_PER_BEAT)) >= {1'b0, len_q};
    assign pkt_end   = hs & last_beat;
    assign cnt_inc   = pkt_cnt_q + 32'd1;
    assign run_end   = ((num_q != 32'd0) && (cnt_inc == num_q)) || stop_q || cfg_stop;

    assign eff_min  = (cfg_min_len == '0) ? LEN_WIDTH'(1) : cfg_min_len;
    // Extra carry bit keeps the wrap comparison correct near the top of the length range.
    assign len_sum  = {1'b0, len_q} + {1'b0, step_q};
    assign len_next = (len_sum > {1'b0, max_q}) ? min_q : len_sum[LEN_WIDTH-1:0];

    // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge tx_mac_aclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: state_d is defaulted first so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) state_d = SEND;
            end
            SEND: begin
                if (pkt_end) begin
                    if (run_end)              state_d = IDLE;
                    else if (gap_q != 8'd0)   state_d = GAP;
                end
            end
            GAP: begin
                if (cfg_stop || stop_q)       state_d = IDLE;
                else if (gap_cnt_q == 8'd0)   state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tx_mac_aclk or posedge reset) begin
        if (reset) begin
            min_q     <= '0;
            max_q     <= '0;
            step_q    <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            num_q     <= '0;
            pkt_cnt_q <= '0;
            beat_q    <= '0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q != IDLE) && (state_d == IDLE);
            if (start_run) begin
                min_q     <= eff_min;
                max_q     <= cfg_max_len;
                step_q    <= cfg_len_step;
                gap_q     <= cfg_gap;
                num_q     <= cfg_num_pkts;
                len_q     <= eff_min;
                pkt_cnt_q <= '0;
                beat_q    <= '0;
                stop_q    <= 1'b0;
            end else begin
                // A stop mid-packet is remembered until the packet's tlast handshake.
                if (valid && cfg_stop) stop_q <= 1'b1;
                if (hs) begin
                    if (last_beat) begin
                        beat_q    <= '0;
                        pkt_cnt_q <= cnt_inc;
                        len_q     <= len_next;
                        gap_cnt_q <= gap_q - 8'd1;
                    end else begin
                        beat_q <= beat_q + BEAT_WIDTH'(1);
                    end
                end
                if (state_q == GAP) gap_cnt_q <= gap_cnt_q - 8'd1;
            end
        end
    end

`ifdef AXIS_TX_ERR_INJ_EN
    logic [7:0] err_every_q, err_phase_q;
    logic       err_pkt;

    // err_phase_q tracks pkt_cnt mod err_every without a divider.
    assign err_pkt = (err_every_q != 8'd0) && (err_phase_q == err_every_q - 8'd1);

    always_ff @(posedge tx_mac_aclk or posedge reset) begin
        if (reset) begin
            err_every_q <= '0;
            err_phase_q <= '0;
        end else if (start_run) begin
            err_every_q <= cfg_err_every;
            err_phase_q <= '0;
        end else if (pkt_end) begin
            err_phase_q <= err_pkt ? 8'd0 : err_phase_q + 8'd1;
        end
    end

    assign flip_byte0 = err_pkt && (beat_q == '0);
    assign err_inj    = hs && flip_byte0;
`else
    assign flip_byte0 = 1'b0;
`endif

    axis_tx_pattern_gen u_pattern (
        .seed       (pkt_cnt_q[7:0]),
        .beat_lsb   (beat_q[4:0]),
        .len_mod    (len_q[2:0]),
        .is_last    (last_beat),
        .flip_byte0 (flip_byte0),
        .data       (pat_data),
        .keep       (pat_keep)
    );

    // Outputs are gated by valid so reset and idle/gap cycles present all-zero beats.
    assign tx_axis_mac_tvalid = valid;
    assign tx_axis_mac_tdata  = valid ? pat_data : '0;
    assign tx_axis_mac_tkeep  = valid ? pat_keep : '0;
    assign tx_axis_mac_tlast  = valid & last_beat;
    assign tx_axis_mac_tbcnt  = valid ? BCNT_WIDTH'(len_q) : '0;
    assign pkt_cnt            = pkt_cnt_q;
    assign busy               = (state_q != IDLE);
    assign done               = done_q;

endmodule

// File: tb/tb_axis_tx_pkt_gen.sv
// Self-checking bench for axis_tx_pkt_gen: directed and randomized runs checked beat by beat
// against a byte-level model of the length sequence and payload pattern.
`timescale 1ns/1ps

module tb_axis_tx_pkt_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start, cfg_stop;
    logic [15:0] cfg_min_len, cfg_max_len, cfg_len_step;
    logic [7:0]  cfg_gap;
    logic [31:0] cfg_num_pkts;
    logic        tready;
    logic        tvalid, tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [31:0] tbcnt;
    logic [31:0] pkt_cnt;
    logic        busy, done;
`ifdef AXIS_TX_ERR_INJ_EN
    logic [7:0]  cfg_err_every;
    logic        err_inj;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axis_tx_pkt_gen dut (
        .tx_mac_aclk        (clk),
        .reset              (reset),
        .cfg_start          (cfg_start),
        .cfg_stop           (cfg_stop),
        .cfg_min_len        (cfg_min_len),
        .cfg_max_len        (cfg_max_len),
        .cfg_len_step       (cfg_len_step),
        .cfg_gap            (cfg_gap),
        .cfg_num_pkts       (cfg_num_pkts),
`ifdef AXIS_TX_ERR_INJ_EN
        .cfg_err_every      (cfg_err_every),
        .err_inj            (err_inj),
`endif
        .tx_axis_mac_tready (tready),
        .tx_axis_mac_tvalid (tvalid),
        .tx_axis_mac_tdata  (tdata),
        .tx_axis_mac_tkeep  (tkeep),
        .tx_axis_mac_tlast  (tlast),
        .tx_axis_mac_tbcnt  (tbcnt),
        .pkt_cnt            (pkt_cnt),
        .busy               (busy),
        .done               (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected beat b of packet n with length len, built byte by byte from the pattern rule.
    function automatic void exp_beat(input int n, input int len, input int b, input bit flip,
                                     output logic [63:0] d, output logic [7:0] kp,
                                     output logic lst);
        int k;
        d  = '0;
        kp = '0;
        for (int j = 0; j < 8; j++) begin
            k = b * 8 + j;
            if (k < len) begin
                kp[j] = 1'b1;
                d[j*8 +: 8] = 8'((n + k) % 256);
                if (k == 0 && flip) d[7:0] = d[7:0] ^ 8'hFF;
            end
        end
        lst = ((b + 1) * 8 >= len);
    endfunction

    // stop_pkt < 0: no stop. stop_beat >= 0: stop during that beat of packet stop_pkt.
    // stop_beat < 0: stop in the third gap cycle before packet stop_pkt.
    // rmode: 0 tready high, 1 tready 1010..., 2 random.
    task automatic run_test(input string name, input int mn, input int mx, input int st,
                            input int gp, input int num, input int errev,
                            input int stop_pkt, input int stop_beat, input int rmode,
                            input int exp_cyc);
        int n, b, len, effmin, cycles, gcount, exp_pkts, done_cnt, stop_cyc;
        bit in_gap, holding, stop_sent, flip;
        logic [63:0] ed, hd;
        logic [7:0]  ek, hk;
        logic        el, hl;
        logic [31:0] hc;

        effmin   = (mn == 0) ? 1 : mn;
        exp_pkts = (stop_pkt < 0) ? num : ((stop_beat >= 0) ? stop_pkt + 1 : stop_pkt);
        n = 0; b = 0; len = effmin; cycles = 0; gcount = 0; done_cnt = 0; stop_cyc = -1;
        in_gap = 0; holding = 0; stop_sent = 0;
        hd = '0; hk = '0; hl = 1'b0; hc = '0;

        @(negedge clk);
        cfg_min_len  = 16'(mn);
        cfg_max_len  = 16'(mx);
        cfg_len_step = 16'(st);
        cfg_gap      = 8'(gp);
        cfg_num_pkts = 32'(num);
`ifdef AXIS_TX_ERR_INJ_EN
        cfg_err_every = 8'(errev);
`endif
        cfg_start = 1'b1;
        tready    = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        // Config must have been captured at start; scramble the inputs for the rest of the run.
        cfg_min_len  = 16'($urandom);
        cfg_max_len  = 16'($urandom);
        cfg_len_step = 16'($urandom);
        cfg_gap      = 8'($urandom);
        cfg_num_pkts = $urandom_range(1, 3);
`ifdef AXIS_TX_ERR_INJ_EN
        cfg_err_every = 8'($urandom);
`endif

        while (busy === 1'b1 && cycles < 3000) begin
            case (rmode)
                0:       tready = 1'b1;
                1:       tready = (cycles % 2 == 0);
                default: tready = 1'($urandom_range(0, 1));
            endcase
            cfg_stop = 1'b0;
            if (!stop_sent && stop_pkt >= 0 && n == stop_pkt) begin
                if ((stop_beat >= 0 && !in_gap && b == stop_beat) ||
                    (stop_beat < 0 && in_gap && gcount == 2)) begin
                    cfg_stop  = 1'b1;
                    stop_sent = 1;
                    stop_cyc  = cycles;
                end
            end
            cfg_start = (cycles == 3);
            #1;
            if (done === 1'b1) done_cnt++;
            if (cycles == 0) check({name, "/first_valid"}, tvalid, 1);
            if (tvalid === 1'b1) begin
                if (in_gap) begin
                    check({name, "/gap_len"}, gcount, gp);
                    in_gap = 0;
                end
                if (holding) begin
                    check({name, "/hold_tdata"}, tdata, hd);
                    check({name, "/hold_tkeep"}, tkeep, hk);
                    check({name, "/hold_tlast"}, tlast, hl);
                    check({name, "/hold_tbcnt"}, tbcnt, hc);
                end
                flip = (errev != 0) && (n % errev == errev - 1);
                exp_beat(n, len, b, flip, ed, ek, el);
                check({name, "/tdata"}, tdata, ed);
                check({name, "/tkeep"}, tkeep, ek);
                check({name, "/tlast"}, tlast, el);
                check({name, "/tbcnt"}, tbcnt, len);
`ifdef AXIS_TX_ERR_INJ_EN
                check({name, "/err_inj"}, err_inj, tready && b == 0 && flip);
`endif
                if (tready) begin
                    holding = 0;
                    if (el) begin
                        n++;
                        b = 0;
                        len = (len + st > mx) ? effmin : len + st;
                        in_gap = 1;
                        gcount = 0;
                    end else begin
                        b++;
                    end
                end else begin
                    holding = 1;
                    hd = tdata; hk = tkeep; hl = tlast; hc = tbcnt;
                end
            end else begin
                check({name, "/valid_only_drops_in_gap"}, in_gap, 1);
                gcount++;
            end
            @(negedge clk);
            cycles++;
        end
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;

        check({name, "/run_ended"}, busy, 0);
        if (done === 1'b1) done_cnt++;
        check({name, "/pkts_seen"}, n, exp_pkts);
        check({name, "/pkt_cnt"}, pkt_cnt, exp_pkts);
        if (exp_cyc >= 0) check({name, "/cycles"}, cycles, exp_cyc);
        if (stop_pkt >= 0 && stop_beat < 0) check({name, "/gap_stop_latency"}, cycles - stop_cyc, 1);
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check({name, "/done_pulses"}, done_cnt, 1);
        check({name, "/pkt_cnt_held"}, pkt_cnt, exp_pkts);
        check({name, "/idle_tvalid"}, tvalid, 0);
    endtask

    initial begin
        reset        = 1'b1;
        cfg_start    = 1'b0;
        cfg_stop     = 1'b0;
        cfg_min_len  = '0;
        cfg_max_len  = '0;
        cfg_len_step = '0;
        cfg_gap      = '0;
        cfg_num_pkts = '0;
        tready       = 1'b0;
`ifdef AXIS_TX_ERR_INJ_EN
        cfg_err_every = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst/tvalid", tvalid, 0);
        check("rst/tdata", tdata, 0);
        check("rst/pkt_cnt", pkt_cnt, 0);
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        reset = 1'b0;

        run_test("len64_b2b",  64, 64, 0, 0, 2, 0, -1,  0, 0, 16);
        run_test("len60_step", 60, 64, 3, 2, 3, 0, -1,  0, 2, -1);
        run_test("len9_toggle", 9,  9, 0, 0, 1, 0, -1,  0, 1, -1);
        run_test("stop_pkt4",  20, 40, 7, 5, 0, 0,  3,  2, 2, -1);
        run_test("stop_gap",   10, 30, 10, 8, 0, 0, 2, -1, 2, -1);
        run_test("min_zero",    0,  0, 0, 1, 3, 0, -1,  0, 0, -1);
        run_test("max_lt_min", 20,  5, 3, 0, 3, 0, -1,  0, 2, -1);

        // Reset mid-packet: packets 0 and 1 (16 bytes each) complete, packet 2 is mid-flight.
        @(negedge clk);
        cfg_min_len  = 16'd16;
        cfg_max_len  = 16'd16;
        cfg_len_step = 16'd0;
        cfg_gap      = 8'd0;
        cfg_num_pkts = 32'd0;
        cfg_start    = 1'b1;
        tready       = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst/pkt_cnt", pkt_cnt, 2);
        reset = 1'b1;
        #1;
        check("mid_rst/tvalid", tvalid, 0);
        check("mid_rst/tdata", tdata, 0);
        check("mid_rst/tkeep", tkeep, 0);
        check("mid_rst/tlast", tlast, 0);
        check("mid_rst/tbcnt", tbcnt, 0);
        check("mid_rst/pkt_cnt", pkt_cnt, 0);
        check("mid_rst/busy", busy, 0);
        check("mid_rst/done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        run_test("after_rst", 17, 30, 5, 1, 3, 0, -1, 0, 2, -1);

`ifdef AXIS_TX_ERR_INJ_EN
        run_test("err_inj", 13, 30, 4, 1, 8, 4, -1, 0, 2, -1);
`endif

        for (int i = 0; i < 6; i++) begin
            int mn, mx, st, gp, num;
            mn  = $urandom_range(0, 70);
            mx  = $urandom_range(0, 80);
            st  = $urandom_range(0, 20);
            gp  = $urandom_range(0, 4);
            num = $urandom_range(1, 5);
            run_test($sformatf("rand%0d", i), mn, mx, st, gp, num, 0, -1, 0, 2, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
